gin_id_config_ctrl: RTL

GIN_ID_CONFIG_CTRL -- requirements
Module: gin_id_config_ctrl

---
 rtl/gin_id_config_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gin_id_config_ctrl.sv
// GIN multicast ID configuration controller: sweeps a stream of IDs into
// NUM_NODES nodes, one registered one-hot set_id strobe per accepted ID,
// then enables GIN traffic once every node has been programmed.
`ifndef XID_BITS
`define XID_BITS 8
`endif

module gin_id_config_ctrl #(
  parameter int unsigned NUM_NODES = 12,
  parameter int unsigned ID_SIZE   = `XID_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic                         cfg_valid,
  input  logic [ID_SIZE-1:0]           cfg_id,
  output logic                         cfg_ready,
  output logic [NUM_NODES-1:0]         set_id,
  output logic [ID_SIZE-1:0]           id_out,
  output logic [$clog2(NUM_NODES)-1:0] node_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         net_en
);

  localparam int unsigned IDX_W = $clog2(NUM_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [NUM_NODES-1:0] set_id_n;
  logic [ID_SIZE-1:0]   id_out_n;
  logic [IDX_W-1:0]     node_idx_n;
  logic                 done_n;
  logic                 net_en_n;

  // Ready is the only combinational output: accept IDs only while loading.
  assign cfg_ready = (state == LOAD);

  // State and all state-derived outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      set_id   <= '0;
      id_out   <= '0;
      node_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      net_en   <= 1'b0;
    end else begin
      state    <= state_n;
      set_id   <= set_id_n;
      id_out   <= id_out_n;
      node_idx <= node_idx_n;
      busy     <= (state_n == LOAD);
      done     <= done_n;
      net_en   <= net_en_n;
    end
  end

  // Next-state and next-output logic; set_id defaults to zero so each
  // strobe lasts exactly one cycle after its transfer.
  always_comb begin
    state_n    = state;
    set_id_n   = '0;
    id_out_n   = id_out;
    node_idx_n = node_idx;
    done_n     = done;
    net_en_n   = net_en;

    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n    = LOAD;
          node_idx_n = '0;
          done_n     = 1'b0;
          net_en_n   = 1'b0;
        end
      end

      LOAD: begin
        // Abort takes priority over a simultaneous transfer.
        if (cfg_abort) begin
          state_n    = IDLE;
          node_idx_n = '0;
          done_n     = 1'b0;
          net_en_n   = 1'b0;
        end else if (cfg_valid) begin
          set_id_n = NUM_NODES'(1) << node_idx;
          id_out_n = cfg_id;
          if (node_idx == LAST_IDX) begin
            state_n    = DONE;
            node_idx_n = '0;
            done_n     = 1'b1;
            net_en_n   = 1'b1;
          end else begin
            node_idx_n = node_idx + IDX_W'(1);
          end
        end
      end

      DONE: begin
        // Restart a sweep; previously loaded node IDs are left alone.
        if (cfg_start) begin
          state_n    = LOAD;
          node_idx_n = '0;
          done_n     = 1'b0;
          net_en_n   = 1'b0;
        end
      end

      default: begin
        state_n    = IDLE;
        node_idx_n = '0;
        done_n     = 1'b0;
        net_en_n   = 1'b0;
      end
    endcase
  end

endmodule
